// File: rtl/cpu_sequencer_if.sv
// Bus between the CPU sequencer and the surrounding datapath: RAM read data and ALU flags in,
// instruction register, program counter, state and datapath strobes out.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 16
);
  logic                enable;
  logic [31:0]         data_out;
  logic [3:0]          flags;
  logic [31:0]         instruction;
  logic [PC_WIDTH-1:0] PC_out;
  logic [1:0]          current_state;
  logic                ram_enable;
  logic                addr_sel;
  logic                reg_write;
  logic                flag_write;
  logic                mem_write;

  // Sequencer side
  modport master (
    input  enable, data_out, flags,
    output instruction, PC_out, current_state,
    output ram_enable, addr_sel, reg_write, flag_write, mem_write
  );

  // Datapath / RAM side
  modport slave (
    output enable, data_out, flags,
    input  instruction, PC_out, current_state,
    input  ram_enable, addr_sel, reg_write, flag_write, mem_write
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM sequencer: owns PC and instruction register and
// issues the RAM, register-bank, flag and store strobes from state plus the registered instruction.
module cpu_sequencer #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.master bus
);

  localparam logic [1:0] FETCH   = 2'b00;
  localparam logic [1:0] DECODE  = 2'b01;
  localparam logic [1:0] EXECUTE = 2'b10;
  localparam logic [1:0] MEM     = 2'b11;

  localparam logic [31:0] NOP_WORD = 32'h0F00_0000;

  logic [1:0]          state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]         ir_reg, ir_next;

  logic [3:0]  op_code;
  logic [3:0]  cond;
  logic        s_bit;
  logic [15:0] imm;

  assign op_code = ir_reg[27:24];
  assign cond    = ir_reg[31:28];
  assign s_bit   = ir_reg[23];
  assign imm     = ir_reg[18:3];

  // One-hot decode of the defined opcodes; 1100-1110 and 1111 fall through as NOP.
  logic [11:0] op_hot;
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_op_decode
      assign op_hot[gi] = (op_code == 4'(gi));
    end
  endgenerate

  logic is_alu, is_cmp, is_ldr, is_str, is_b;
  assign is_alu = |op_hot[7:0];
  assign is_cmp = op_hot[8];
  assign is_ldr = op_hot[9];
  assign is_str = op_hot[10];
  assign is_b   = op_hot[11];

  // flags = {N, Z, C, V}
  logic branch_taken;
  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      4'b0000: branch_taken = 1'b1;
      4'b0001: branch_taken = bus.flags[2];
      4'b0010: branch_taken = ~bus.flags[2] & (bus.flags[3] == bus.flags[0]);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      FETCH: begin
        if (bus.enable) begin
          ir_next    = bus.data_out;
          pc_next    = pc_reg + PC_WIDTH'(1);
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = EXECUTE;
      end
      EXECUTE: begin
        if (is_b && branch_taken) begin
          pc_next = PC_WIDTH'(imm);
        end
        state_next = (is_ldr || is_str) ? MEM : FETCH;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_WORD;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  logic in_fetch, in_execute, in_mem;
  assign in_fetch   = (state_reg == FETCH);
  assign in_execute = (state_reg == EXECUTE);
  assign in_mem     = (state_reg == MEM);

  // The fetch enable is qualified by reset so the RAM strobe stays low while reset is held.
  assign bus.ram_enable = (in_fetch & bus.enable & reset) | in_mem;
  assign bus.reg_write  = (in_execute & is_alu) | (in_mem & is_ldr);
  assign bus.flag_write = in_execute & ((is_alu & s_bit) | is_cmp);
  assign bus.mem_write  = in_mem & is_str;

  // Register/flag writebacks in EXECUTE also steer the address mux away from the PC,
  // so no write strobe is ever seen together with addr_sel=0.
  assign bus.addr_sel = in_mem | (in_execute & (is_alu | is_cmp));

  assign bus.instruction   = ir_reg;
  assign bus.PC_out        = pc_reg;
  assign bus.current_state = state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a RAM model feeds a small program, expected per-instruction
// behaviour is queued at issue time and compared when the sequencer returns to FETCH.
module tb_cpu_sequencer;

  logic clk;
  logic reset;

  cpu_sequencer_if #(.PC_WIDTH(16)) bus ();

  cpu_sequencer #(
    .PC_WIDTH(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:65535];
  assign bus.data_out = bus.addr_sel ? 32'hDEAD_BEEF : ram[bus.PC_out];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cycles;
    logic [7:0]  seq;
    logic [3:0]  rw_m;
    logic [3:0]  fw_m;
    logic [3:0]  mw_m;
    logic [3:0]  re_m;
    logic [15:0] pc_after;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural model of one instruction; masks have bit k set when the strobe is high in cycle k+1.
  function automatic exp_t model(input logic [31:0] w, input logic [15:0] pc, input logic [3:0] f);
    exp_t       e;
    logic [3:0] op;
    logic [3:0] cd;
    logic       taken;
    op = w[27:24];
    cd = w[31:28];
    e.instr    = w;
    e.cycles   = 4'd3;
    e.seq      = 8'h06;
    e.rw_m     = 4'b0000;
    e.fw_m     = 4'b0000;
    e.mw_m     = 4'b0000;
    e.re_m     = 4'b0001;
    e.pc_after = pc + 16'd1;
    if (op <= 4'd7) begin
      e.rw_m = 4'b0100;
      e.fw_m = w[23] ? 4'b0100 : 4'b0000;
    end else if (op == 4'd8) begin
      e.fw_m = 4'b0100;
    end else if (op == 4'd9 || op == 4'd10) begin
      e.cycles = 4'd4;
      e.seq    = 8'h1B;
      e.re_m   = 4'b1001;
      if (op == 4'd9) e.rw_m = 4'b1000;
      else            e.mw_m = 4'b1000;
    end else if (op == 4'd11) begin
      taken = (cd == 4'd0) || (cd == 4'd1 && f[2]) ||
              (cd == 4'd2 && !f[2] && (f[3] == f[0]));
      if (taken) e.pc_after = w[18:3];
    end
    return e;
  endfunction

  // Monitor: tracks one instruction from its FETCH cycle to the next FETCH entry.
  initial begin
    bit         active;
    int         cyc;
    logic [7:0] seq;
    logic [3:0] rw_m, fw_m, mw_m, re_m;
    exp_t       e;
    active = 0;
    cyc = 0;
    seq = '0;
    rw_m = '0; fw_m = '0; mw_m = '0; re_m = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 0;
      end else begin
        if (bus.reg_write || bus.flag_write || bus.mem_write)
          check("addr_sel_w", 32'(bus.addr_sel), 32'd1);
        if (bus.current_state == 2'b11)
          check("addr_sel_mem", 32'(bus.addr_sel), 32'd1);
        if (active && bus.current_state == 2'b00) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("instr",  bus.instruction, e.instr);
            check("cycles", 32'(cyc), 32'(e.cycles));
            check("states", 32'(seq), 32'(e.seq));
            check("reg_wr", 32'(rw_m), 32'(e.rw_m));
            check("flag_wr", 32'(fw_m), 32'(e.fw_m));
            check("mem_wr", 32'(mw_m), 32'(e.mw_m));
            check("ram_en", 32'(re_m), 32'(e.re_m));
            check("pc",     32'(bus.PC_out), 32'(e.pc_after));
            $display("instr word=%h cycles=%0d pc_after=%h rw=%b fw=%b mw=%b",
                     bus.instruction, cyc, bus.PC_out, rw_m, fw_m, mw_m);
          end
          active = 0;
        end
        if (!active && bus.current_state == 2'b00 && bus.ram_enable) begin
          active = 1;
          cyc = 1;
          seq = 8'(bus.current_state);
          rw_m = {3'b000, bus.reg_write};
          fw_m = {3'b000, bus.flag_write};
          mw_m = {3'b000, bus.mem_write};
          re_m = {3'b000, bus.ram_enable};
        end else if (active && bus.current_state != 2'b00) begin
          cyc++;
          seq = {seq[5:0], bus.current_state};
          if (cyc <= 4) begin
            rw_m[cyc-1] = bus.reg_write;
            fw_m[cyc-1] = bus.flag_write;
            mw_m[cyc-1] = bus.mem_write;
            re_m[cyc-1] = bus.ram_enable;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [3:0]  step_flags [0:16];
  logic [15:0] pc_model;
  exp_t        e_new;

  initial begin
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.flags = 4'b0000;
    for (int a = 0; a < 65536; a++) ram[a] = 32'h0F00_0000;
    ram[16'h0000] = 32'h0618_0020;  // MOV R3,#4
    ram[16'h0001] = 32'h0955_2000;  // LDR
    ram[16'h0002] = 32'h0080_0000;  // ADD with S
    ram[16'h0003] = 32'h0800_0000;  // CMP
    ram[16'h0004] = 32'h1B00_0200;  // B EQ 0x0040
    ram[16'h0005] = 32'h0D00_0000;  // undefined -> NOP
    ram[16'h0006] = 32'h3B00_0080;  // B cond 0011 0x0010
    ram[16'h0007] = 32'h0B00_0100;  // B AL 0x0020
    ram[16'h0020] = 32'h0A00_0000;  // STR
    ram[16'h0040] = 32'h1B00_0400;  // B EQ 0x0080
    ram[16'h0041] = 32'h0A00_0000;  // STR
    ram[16'h0042] = 32'h2B07_FFF8;  // B GT 0xFFFF
    ram[16'hFFFF] = 32'h0F00_0000;  // NOP
    step_flags = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0100,
                   4'b1111};

    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.current_state), 32'd0);
    check("rst_pc",    32'(bus.PC_out), 32'h0000);
    check("rst_instr", bus.instruction, 32'h0F00_0000);
    check("rst_strobes", 32'({bus.ram_enable, bus.addr_sel, bus.reg_write, bus.flag_write,
                              bus.mem_write}), 32'd0);

    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("park_state", 32'(bus.current_state), 32'd0);
      check("park_ram_en", 32'(bus.ram_enable), 32'd0);
      check("park_pc", 32'(bus.PC_out), 32'h0000);
    end

    pc_model = 16'h0000;
    for (int i = 0; i < 17; i++) begin
      bus.flags = step_flags[i];
      e_new = model(ram[pc_model], pc_model, step_flags[i]);
      sb_q.push_back(e_new);
      pc_model = e_new.pc_after;
      if (i == 0 || i == 11) begin
        @(posedge clk);
        #1 bus.enable = 1'b1;
        if (i == 11) begin
          @(negedge clk);
          check("resume_ram_en", 32'(bus.ram_enable), 32'd1);
          @(negedge clk);
          check("resume_decode", 32'(bus.current_state), 32'd1);
        end
      end
      if (i == 10) begin
        for (int c = 0; c < 8 && bus.current_state != 2'b01; c++) @(negedge clk);
        check("drop_in_decode", 32'(bus.current_state), 32'd1);
        bus.enable = 1'b0;
      end
      for (int c = 0; c < 12 && sb_q.size() != 0; c++) @(negedge clk);
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      if (i == 10) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("repark_state", 32'(bus.current_state), 32'd0);
          check("repark_ram_en", 32'(bus.ram_enable), 32'd0);
          check("repark_pc", 32'(bus.PC_out), 32'h0002);
        end
      end
    end

    // The STR at 0x0020 is fetched next; reset it in the middle of MEM.
    for (int c = 0; c < 10 && bus.current_state != 2'b11; c++) @(negedge clk);
    check("str_mem", 32'(bus.current_state), 32'd3);
    check("str_mem_write", 32'(bus.mem_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_write", 32'(bus.mem_write), 32'd0);
    check("abort_state", 32'(bus.current_state), 32'd0);
    check("abort_pc", 32'(bus.PC_out), 32'h0000);
    check("abort_instr", bus.instruction, 32'h0F00_0000);
    check("abort_strobes", 32'({bus.ram_enable, bus.addr_sel, bus.reg_write, bus.flag_write}),
          32'd0);
    repeat (2) @(negedge clk);
    check("hold_state", 32'(bus.current_state), 32'd0);
    check("hold_ram_en", 32'(bus.ram_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
